// File: rtl/fifo_skid2.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_skid2
//  Purpose  : Two-entry in-order holding buffer; entry 0 is the head word.
//  Revision : 1.0
// ============================================================================
module fifo_skid2 #(
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [DATA-1:0] din,
    output logic [1:0]      occ,
    output logic [DATA-1:0] head
);

    logic [1:0]      r_occ;
    logic [DATA-1:0] r_ent0;
    logic [DATA-1:0] r_ent1;

    // Flush only drops occupancy; the head word stays visible, matching the
    // "holds its last value when empty" behaviour of the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else if (flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_ent0 <= din;
                    else               r_ent1 <= din;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= din;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ  = r_occ;
    assign head = r_ent0;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (r_occ == 2'd2)));

    a_occ_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_occ != 2'd3);

endmodule
`default_nettype wire

// File: rtl/fifo_rdstage.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rdstage
//  Purpose  : FIFO read stage; issues reads, absorbs 1-cycle RAM latency and
//             presents words on a valid/ready stream, honouring flush.
//  Revision : 1.0
// ============================================================================
module fifo_rdstage #(
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            notempty,
    output logic            fiford,
    input  logic [DATA-1:0] mem_rdata,
    input  logic            fifoflsh,
    output logic            out_vld,
    output logic [DATA-1:0] out_dat,
    input  logic            out_rdy,
    output logic [1:0]      occ
);

    logic       r_inflight;
    logic       w_pop;
    logic       w_push;
    logic [2:0] w_committed;
    logic [1:0] w_occ;

    assign w_pop  = out_vld & out_rdy;
    assign w_push = r_inflight & ~fifoflsh;

    // Words already held plus the one returning, minus the one leaving now;
    // a new read is only issued if that leaves a free slot for it.
    assign w_committed = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fiford      = rst_n & notempty & ~fifoflsh & (w_committed < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fiford;
        end
    end

    fifo_skid2 #(
        .DATA (DATA)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifoflsh),
        .push  (w_push),
        .pop   (w_pop),
        .din   (mem_rdata),
        .occ   (w_occ),
        .head  (out_dat)
    );

    assign out_vld = (w_occ != 2'd0);
    assign occ     = w_occ;

    a_rd_needs_data : assert property (@(posedge clk) disable iff (!rst_n)
        fiford |-> notempty);

endmodule
`default_nettype wire
